// File: rtl/tm1638_pkg.sv
// Shared command encodings, FSM states and helpers for the TM1638 responder model.
package tm1638_pkg;

  localparam int ADDR_W = 4;

  localparam logic [7:0] DATA_CMD   = 8'h40;
  localparam logic [7:0] DATA_MASK  = 8'hC0;
  localparam logic [7:0] ADDR_CMD   = 8'hC0;
  localparam logic [7:0] ADDR_MASK  = 8'hF0;
  localparam logic [7:0] DISP_CMD   = 8'h80;
  localparam logic [7:0] DISP_MASK  = 8'hF0;

  localparam logic [1:0] XFER_WRITE = 2'b00;
  localparam logic [1:0] XFER_READ  = 2'b10;
  localparam int         FIXED_BIT   = 2;
  localparam int         DISP_ON_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    CLS_DATA,
    CLS_ADDR,
    CLS_DISP,
    CLS_OTHER
  } cmd_class_t;

  function automatic cmd_class_t classify(input logic [7:0] b);
    if ((b & DATA_MASK) == DATA_CMD)      return CLS_DATA;
    else if ((b & ADDR_MASK) == ADDR_CMD) return CLS_ADDR;
    else if ((b & DISP_MASK) == DISP_CMD) return CLS_DISP;
    else                                  return CLS_OTHER;
  endfunction

endpackage

// File: rtl/tm1638_line_sync.sv
// Multi-flop synchroniser for one asynchronous line, with edge pulses derived
// from the synchronised level.
module tm1638_line_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: flops use non-blocking assignments so each stage takes the pre-edge value of the one before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 responder: decodes the 3-wire command stream, holds the display RAM
// and settings, and shifts out a latched key-scan image on read commands.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = 16,
  parameter int IN_BYTES    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   cs,
  input  logic                   dio_i,
  output logic                   dio_o,
  output logic                   dio_e,
  input  logic [8*IN_BYTES-1:0]  key_data,
  output logic [8*NUM_BYTES-1:0] disp_mem,
  output logic                   disp_on,
  output logic [2:0]             brightness,
  output logic                   frame_done
);

  logic sck_rise, sck_fall, sck_unused;
  logic cs_s, cs_rise, cs_fall;
  logic dio_s, dio_rise_unused, dio_fall_unused;

  // sck and cs idle high, so they reset high to avoid a false edge after reset.
  tm1638_line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck_sync (
    .clk(clk), .rst_n(reset), .d(sck),
    .sync(sck_unused), .rise(sck_rise), .fall(sck_fall)
  );

  tm1638_line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(reset), .d(cs),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  tm1638_line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dio_sync (
    .clk(clk), .rst_n(reset), .d(dio_i),
    .sync(dio_s), .rise(dio_rise_unused), .fall(dio_fall_unused)
  );

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [6:0]            shift_q;
  logic                  byte_seen;
  logic                  fixed;
  logic [ADDR_W-1:0]     addr;
  logic [8*IN_BYTES-1:0] key_lat;

  logic [7:0] rx_byte;
  logic       bit_strobe;

  // The byte being completed: the current line value lands in the MSB (LSB-first).
  assign rx_byte    = {dio_s, shift_q};
  assign bit_strobe = sck_rise & ~cs_s & (state != ST_IDLE);

  // Only the fixed-address bit of the mode register changes behaviour; writes
  // land in disp_mem whatever the read/write mode says.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      byte_seen  <= 1'b0;
      fixed      <= 1'b0;
      addr       <= '0;
      key_lat    <= '0;
      // NOTE: the display RAM is reset as well, because reset must visibly clear it.
      disp_mem   <= '0;
      disp_on    <= 1'b0;
      brightness <= '0;
      dio_o      <= 1'b0;
      dio_e      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_rise) begin
        // cs rise beats any sck edge in the same cycle; a partial byte is dropped.
        state      <= ST_IDLE;
        dio_e      <= 1'b0;
        dio_o      <= 1'b0;
        frame_done <= byte_seen;
        byte_seen  <= 1'b0;
        bit_cnt    <= '0;
      end else if (cs_fall) begin
        state     <= ST_CMD;
        bit_cnt   <= '0;
        byte_seen <= 1'b0;
      end else begin
        if (bit_strobe) begin
          shift_q <= rx_byte[7:1];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_seen <= 1'b1;
            case (state)
              ST_CMD: begin
                case (classify(rx_byte))
                  CLS_DATA: begin
                    if (rx_byte[1:0] == XFER_WRITE) begin
                      fixed <= rx_byte[FIXED_BIT];
                      state <= ST_IGNORE;
                    end else if (rx_byte[1:0] == XFER_READ) begin
                      key_lat <= key_data;
                      dio_e   <= 1'b1;
                      state   <= ST_READ;
                    end else begin
                      state <= ST_IGNORE;
                    end
                  end
                  CLS_ADDR: begin
                    addr  <= rx_byte[ADDR_W-1:0];
                    state <= ST_WRITE;
                  end
                  CLS_DISP: begin
                    disp_on    <= rx_byte[DISP_ON_BIT];
                    brightness <= rx_byte[2:0];
                    state      <= ST_IGNORE;
                  end
                  default: state <= ST_IGNORE;
                endcase
              end
              ST_WRITE: begin
                disp_mem[{addr, 3'b000} +: 8] <= rx_byte;
                if (!fixed) addr <= addr + ADDR_W'(1);
              end
              default: ;
            endcase
          end
        end
        // Shifting the latched image right leaves zeros once every key bit is out.
        if (sck_fall && state == ST_READ) begin
          dio_o   <= key_lat[0];
          key_lat <= key_lat >> 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder: directed frame table, read and
// corner-case sequences, and random frames checked against a behavioural model.
module tb_tm1638_responder;

  localparam int H = 8;  // clk cycles per sck half-period

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sck = 1'b1;
  logic         cs = 1'b1;
  logic         dio_i = 1'b0;
  logic [31:0]  key_data = '0;
  logic         dio_o, dio_e, disp_on, frame_done;
  logic [127:0] disp_mem;
  logic [2:0]   brightness;

  tm1638_responder #(.SYNC_STAGES(2), .NUM_BYTES(16), .IN_BYTES(4)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .dio_i(dio_i),
    .dio_o(dio_o), .dio_e(dio_e), .key_data(key_data), .disp_mem(disp_mem),
    .disp_on(disp_on), .brightness(brightness), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_seen  = 0;

  always @(negedge clk) if (frame_done) fd_seen++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model of the observable responder state.
  logic [7:0] model_mem [16];
  int         model_addr;
  bit         model_fixed;
  bit         model_on;
  int         model_bri;
  int         exp_fd;
  logic [7:0] frame_buf [8];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_addr = 0; model_fixed = 0; model_on = 0; model_bri = 0;
  endtask

  task automatic model_frame(input int nbytes);
    int b;
    if (nbytes == 0) return;
    exp_fd++;
    b = int'(frame_buf[0]);
    if (b >= 'h40 && b <= 'h7F) begin
      if (b % 4 == 0) model_fixed = ((b / 4) % 2) == 1;
    end else if (b >= 'hC0 && b <= 'hCF) begin
      model_addr = b - 'hC0;
      for (int i = 1; i < nbytes; i++) begin
        model_mem[model_addr] = frame_buf[i];
        if (!model_fixed) model_addr = (model_addr + 1) % 16;
      end
    end else if (b >= 'h80 && b <= 'h8F) begin
      model_on  = ((b / 8) % 2) == 1;
      model_bri = b % 8;
    end
  endtask

  function automatic logic [127:0] model_image();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = model_mem[i];
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".mem"}, disp_mem, model_image());
    check({tag, ".on"}, 128'(disp_on), 128'(model_on));
    check({tag, ".bri"}, 128'(brightness), 128'(model_bri));
    check({tag, ".frame_done"}, 128'(fd_seen), 128'(exp_fd));
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0; dio_i = b[i]; wait_clks(H);
      sck = 1'b1; wait_clks(H);
    end
  endtask

  task automatic run_frame(input int nbytes, input int tail_bits, input logic [7:0] tail);
    cs = 1'b0; wait_clks(H);
    for (int i = 0; i < nbytes; i++) send_bits(frame_buf[i], 8);
    if (tail_bits > 0) send_bits(tail, tail_bits);
    cs = 1'b1; wait_clks(H);
    model_frame(nbytes);
  endtask

  // Read frame: command 0x42 then 34 clocks, sampling dio_o just before each rise.
  task automatic read_frame(input logic [31:0] img, input bit change_mid, input string tag);
    logic [33:0] got;
    bit          e_ok;
    int          k;
    key_data = img; e_ok = 1;
    frame_buf[0] = 8'h42;
    cs = 1'b0; wait_clks(H);
    send_bits(8'h42, 8);
    for (int i = 0; i < 34; i++) begin
      sck = 1'b0; wait_clks(H);
      got[i] = dio_o;
      if (dio_e !== 1'b1) e_ok = 0;
      sck = 1'b1; wait_clks(H);
      if (change_mid && i == 7) key_data = ~img;
    end
    for (int j = 0; j < 4; j++)
      check($sformatf("%s.byte%0d", tag, j), 128'(got[8*j +: 8]), 128'(img[8*j +: 8]));
    check({tag, ".tail_zero"}, 128'(got[33:32]), 128'(0));
    check({tag, ".dio_e_held"}, 128'(e_ok), 128'(1));
    cs = 1'b1;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (dio_e === 1'b0) begin k = c; break; end
    end
    check({tag, ".dio_e_drop_ok"}, 128'(k >= 2 && k <= 4), 128'(1));
    wait_clks(H);
    model_frame(1);
  endtask

  typedef struct packed {
    logic [2:0]  len;
    logic [31:0] bytes;     // first byte in [7:0]
    logic [3:0]  idx;
    logic [7:0]  exp_byte;
    logic        exp_on;
    logic [2:0]  exp_bri;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd1, 32'h0000_0040, 4'd0,  8'h00, 1'b0, 3'd0};
    vecs[1]  = '{3'd4, 32'h3322_11C0, 4'd0,  8'h11, 1'b0, 3'd0};
    vecs[2]  = '{3'd0, 32'h0,         4'd1,  8'h22, 1'b0, 3'd0};
    vecs[3]  = '{3'd0, 32'h0,         4'd2,  8'h33, 1'b0, 3'd0};
    vecs[4]  = '{3'd0, 32'h0,         4'd3,  8'h00, 1'b0, 3'd0};
    vecs[5]  = '{3'd1, 32'h0000_0044, 4'd15, 8'h00, 1'b0, 3'd0};
    vecs[6]  = '{3'd3, 32'h0055_AAC5, 4'd5,  8'h55, 1'b0, 3'd0};
    vecs[7]  = '{3'd0, 32'h0,         4'd6,  8'h00, 1'b0, 3'd0};
    vecs[8]  = '{3'd1, 32'h0000_0040, 4'd4,  8'h00, 1'b0, 3'd0};
    vecs[9]  = '{3'd4, 32'h0302_01CE, 4'd14, 8'h01, 1'b0, 3'd0};
    vecs[10] = '{3'd0, 32'h0,         4'd15, 8'h02, 1'b0, 3'd0};
    vecs[11] = '{3'd0, 32'h0,         4'd0,  8'h03, 1'b0, 3'd0};
    vecs[12] = '{3'd1, 32'h0000_008C, 4'd1,  8'h22, 1'b1, 3'd4};
    vecs[13] = '{3'd1, 32'h0000_0080, 4'd2,  8'h33, 1'b0, 3'd0};

    model_reset();
    exp_fd = 0;

    wait_clks(3);
    check("rst.mem", disp_mem, 128'(0));
    check("rst.on_bri_outs", 128'({disp_on, brightness, dio_o, dio_e, frame_done}), 128'(0));
    reset = 1'b1;
    wait_clks(H);

    // Directed table
    for (int r = 0; r < 14; r++) begin
      if (vecs[r].len != 0) begin
        for (int i = 0; i < 4; i++) frame_buf[i] = vecs[r].bytes[8*i +: 8];
        run_frame(int'(vecs[r].len), 0, 8'h00);
      end
      check($sformatf("vec%0d.mem[%0d]", r, vecs[r].idx),
            128'(disp_mem[8*vecs[r].idx +: 8]), 128'(vecs[r].exp_byte));
      check($sformatf("vec%0d.on", r), 128'(disp_on), 128'(vecs[r].exp_on));
      check($sformatf("vec%0d.bri", r), 128'(brightness), 128'(vecs[r].exp_bri));
      if (r == 1) check("vec1.frame_done_count", 128'(fd_seen), 128'(2));
    end
    check("table.frame_done_count", 128'(fd_seen), 128'(8));
    check_state("table");

    // Partial byte after cs rise: no write, next frame decodes a fresh command.
    frame_buf[0] = 8'h40; run_frame(1, 0, 8'h00);
    frame_buf[0] = 8'hC3; frame_buf[1] = 8'h77; run_frame(2, 5, 8'h99);
    check("partial.mem[3]", 128'(disp_mem[8*3 +: 8]), 128'(8'h77));
    check("partial.mem[4]", 128'(disp_mem[8*4 +: 8]), 128'(8'h00));
    frame_buf[0] = 8'h8A; run_frame(1, 0, 8'h00);
    check("partial.next_cmd", 128'({disp_on, brightness}), 128'(4'hA));
    // A frame with only a few bits completes no byte and must not pulse frame_done.
    run_frame(0, 3, 8'hFF);
    check_state("partial");

    // Read with key_data changed mid-frame
    read_frame({8'h11, 8'h00, 8'h10, 8'h01}, 1'b1, "read");
    check_state("read");

    // Random frames
    for (int f = 0; f < 30; f++) begin
      int cat, nbytes, tail;
      cat = $urandom_range(0, 5);
      case (cat)
        0:       frame_buf[0] = 8'h40 | 8'($urandom_range(0, 63));
        4:       frame_buf[0] = 8'h80 | 8'($urandom_range(0, 15));
        5:       frame_buf[0] = 8'($urandom);
        default: frame_buf[0] = 8'hC0 | 8'($urandom_range(0, 15));
      endcase
      nbytes = ($urandom_range(0, 9) == 0) ? 0 : 1 + $urandom_range(0, 5);
      for (int i = 1; i < 8; i++) frame_buf[i] = 8'($urandom);
      tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(nbytes, tail, 8'($urandom));
      check_state($sformatf("rand%0d", f));
    end

    read_frame($urandom, 1'b0, "read2");
    check_state("read2");

    // Reset during READ clears everything at once.
    key_data = 32'hA5A5_5A5A;
    cs = 1'b0; wait_clks(H);
    send_bits(8'h42, 8);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b0; wait_clks(H); sck = 1'b1; wait_clks(H);
    end
    check("rstread.dio_e_before", 128'(dio_e), 128'(1));
    check("rstread.mem_nonzero", 128'(disp_mem != '0), 128'(model_image() != '0));
    reset = 1'b0;
    #1;
    check("rstread.dio_e", 128'(dio_e), 128'(0));
    check("rstread.mem", disp_mem, 128'(0));
    cs = 1'b1; sck = 1'b1;
    wait_clks(H);
    reset = 1'b1;
    wait_clks(H);
    model_reset();
    check_state("rstread");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
